// File: rtl/cdc_sync_bank_if.sv
// Bus bundle for cdc_sync_bank: asynchronous Gray inputs in, synchronized
// Gray/binary values, change strobes and violation flags out.
interface cdc_sync_bank_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2
);
    logic [CHANNELS*WIDTH-1:0] d_in;
    logic                      err_clr;
    logic [CHANNELS*WIDTH-1:0] d_out;
    logic [CHANNELS*WIDTH-1:0] bin_out;
    logic [CHANNELS-1:0]       chg;
    logic [CHANNELS-1:0]       gray_err;
    logic                      ready;

    modport master (
        output d_in, err_clr,
        input  d_out, bin_out, chg, gray_err, ready
    );

    modport slave (
        input  d_in, err_clr,
        output d_out, bin_out, chg, gray_err, ready
    );
endinterface

// File: rtl/cdc_sync_bank.sv
// Multi-channel Gray-bus synchronizer: STAGES-deep flop chain per bit, binary
// conversion, per-channel change strobes and a settle-masked sticky Gray monitor.
module cdc_sync_bank #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int STAGES   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    cdc_sync_bank_if.slave  bus
);
    localparam int BUS_W = CHANNELS * WIDTH;
    localparam int CNT_W = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STAGES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGES - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("cdc_sync_bank: STAGES must be at least 2");
    end
    if (WIDTH < 1 || CHANNELS < 1) begin : g_bad_shape
        $error("cdc_sync_bank: WIDTH and CHANNELS must be at least 1");
    end

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic multi_bit(input logic [WIDTH-1:0] x);
        return |(x & (x - 1'b1));
    endfunction

    logic [BUS_W-1:0]    sync_p [STAGES];
    logic [CNT_W-1:0]    settle_cnt;
    logic                ready_r;
    logic [CHANNELS-1:0] chg_r;
    logic [CHANNELS-1:0] err_r;
    logic [CHANNELS-1:0] chg_nxt;
    logic [CHANNELS-1:0] set_nxt;
    logic [BUS_W-1:0]    bin_nxt;

    always_comb begin
        chg_nxt = '0;
        set_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            chg_nxt[c] = sync_p[STAGES-2][c*WIDTH +: WIDTH] != sync_p[STAGES-1][c*WIDTH +: WIDTH];
            set_nxt[c] = ready_r &&
                         multi_bit(sync_p[STAGES-2][c*WIDTH +: WIDTH] ^ sync_p[STAGES-1][c*WIDTH +: WIDTH]);
        end
    end

    // Chain, strobes, sticky flags and settle tracking all share one reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_p[i] <= '0;
            end
            settle_cnt <= '0;
            ready_r    <= 1'b0;
            chg_r      <= '0;
            err_r      <= '0;
        end else begin
            sync_p[0] <= bus.d_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
            if (settle_cnt != CNT_MAX) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
            ready_r <= ready_r | (settle_cnt >= CNT_LAST);
            chg_r   <= chg_nxt;
            err_r   <= set_nxt | (err_r & ~{CHANNELS{bus.err_clr}});
        end
    end

    always_comb begin
        bin_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bin_nxt[c*WIDTH +: WIDTH] = gray2bin(sync_p[STAGES-1][c*WIDTH +: WIDTH]);
        end
    end

    assign bus.d_out    = sync_p[STAGES-1];
    assign bus.bin_out  = bin_nxt;
    assign bus.chg      = chg_r;
    assign bus.gray_err = err_r;
    assign bus.ready    = ready_r;
endmodule

// File: doc/cdc_sync_bank.md
# cdc_sync_bank

Multi-channel, depth-configurable destination-domain synchronizer for the dual-clock FIFO. It captures CHANNELS asynchronous Gray-coded buses (FIFO read/write pointers, status words) through a STAGES-deep flop chain in the clk domain. It also provides:
- binary-converted pointer values;
- per-channel change strobes;
- a sticky Gray-coding violation monitor that stays masked until the chain has settled after reset.

## Interface
- WIDTH, 4, bits per channel; must be ≥1.
- CHANNELS, 2, number of independent buses; must be ≥1.
- STAGES, 2, flops per bit in the synchronizing chain; values <2 are an elaboration error.
- clk  input  1  destination-domain clock.
- rst_n  input  1  reset; synchronous, active-low; clock clk.
- d_in  input  CHANNELS*WIDTH  asynchronous Gray-coded inputs; channel c occupies bits [c*WIDTH +: WIDTH].
- err_clr  input  1  synchronous clear of all gray_err bits.
- d_out  output  CHANNELS*WIDTH  synchronized Gray value (last chain stage).
- bin_out  output  CHANNELS*WIDTH  Gray-to-binary of d_out, per channel; combinational from d_out.
- chg  output  CHANNELS  one-cycle strobe; high in the cycle d_out[c] shows a new value.
- gray_err  output  CHANNELS  sticky flag; a d_out update changed more than one bit.
- ready  output  1  chain settled; gray_err detection enabled.

## Operation
- Chain: stage[0] <= d_in; stage[i] <= stage[i-1]; d_out = stage[STAGES-1]. Only stage[0] samples d_in. No logic between stages.
- Reset (rst_n=0 at a clk edge): all stages, chg, gray_err, ready and the settle counter go to 0. d_out and bin_out therefore read 0.
- Settle counter: 0 in reset. Increments each edge with rst_n=1, saturating at STAGES. ready is registered and becomes 1 at the edge where the counter reaches STAGES.
- chg[c] is registered as (stage[STAGES-2] slice c != stage[STAGES-1] slice c), so it is co-timed with the d_out update.
- gray_err[c] sets at the same edge chg[c] would set, when both of the following hold:
  - popcount(old ^ new) > 1;
  - ready is already 1.
- gray_err[c] holds until err_clr=1. If set and clear fire in the same cycle, set wins. rst_n also clears it.
- bin_out: bin[W-1] = g[W-1]; bin[i] = bin[i+1] ^ g[i]. Each channel is converted independently.
- Channels are fully independent. There is no cross-channel coherence guarantee.
- Reset mid-operation: everything returns to reset values at that edge, and the settle sequence restarts after release.

## Timing
- Latency d_in→d_out is STAGES clk edges. With STAGES=2, a value stable before edge k is captured at k and appears on d_out after edge k+1.
- chg and gray_err change at the same edge as d_out. bin_out is valid in the same cycle as d_out.
- ready rises after the STAGES-th edge following rst_n release, and stays 1 until the next reset.
- Throughput: one d_out update per cycle per channel. Back-to-back chg pulses are allowed.
- During the settle window (ready=0):
  - d_out still propagates and chg still strobes;
  - only gray_err is masked.
- err_clr has one-cycle effect: gray_err reads 0 on the cycle after the clearing edge, unless a new violation was set at that edge.

## Test plan
- Reset/settle (STAGES=3): hold rst_n=0 for 4 cycles, then release with d_in=0.
  - During reset: all outputs 0.
  - ready=0 for 2 edges after release, then 1 after the 3rd edge.
- Latency and chg (STAGES=2, WIDTH=4): channel 0 d_in goes 0000→0001 before edge k.
  - d_out[3:0]=0001 and chg[0]=1 after edge k+1.
  - chg[0]=0 the next cycle; chg[1] stays 0 throughout.
- Gray walk: drive channel 1 through Gray codes 0..15 (0000, 0001, 0011, 0010, …), one per cycle.
  - bin_out[7:4] follows 0..15 delayed STAGES cycles.
  - chg[1] is high every cycle; gray_err stays 0.
- Violation and sticky clear (after ready=1): channel 0 jumps 0000→0011.
  - gray_err[0]=1 co-timed with d_out.
  - It holds for 10 cycles.
  - err_clr pulse → 0 the next cycle.
  - Repeat with err_clr asserted in the same cycle as a new violation → gray_err[0] stays 1.
- Masked window: apply 0000→1111 on channel 0 within one cycle of rst_n release.
  - d_out shows 1111 and chg[0] pulses.
  - gray_err[0] stays 0.
- Mid-operation reset: during the Gray walk, assert rst_n=0 for 1 cycle.
  - At that edge d_out, chg, gray_err and ready all go to 0.
  - The settle sequence repeats before gray_err can set again.
